// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the scanout slice.
// Counter widths, porch/sync geometry and colours.
package vga_timing_pkg;
  localparam int HW = 10;
  localparam int VW = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int HS_START  = H_VISIBLE + H_FP;
  localparam int HS_END    = HS_START + H_SYNC - 1;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int RD_LAT    = 1;

  localparam logic [4:0] FG_COLOR = 5'b11111;
  localparam logic [4:0] BG_COLOR = 5'b00000;

  typedef logic [HW-1:0] hcnt_t;
  typedef logic [VW-1:0] vcnt_t;
endpackage

// File: rtl/vga_scanout_if.sv
// Decoded timing strobes from the counter block to the scanout datapath.
// Master drives, slave consumes.
interface vga_scanout_if;
  import vga_timing_pkg::*;

  logic  hsync_n;
  logic  vsync_n;
  logic  visible;
  logic  vblank;
  logic  frame_start;
  logic  fetch;
  logic  line_end;
  logic  next_vis;
  vcnt_t next_line;

  modport master (
    output hsync_n, vsync_n, visible, vblank,
    output frame_start, fetch, line_end,
    output next_vis, next_line
  );

  modport slave (
    input hsync_n, vsync_n, visible, vblank,
    input frame_start, fetch, line_end,
    input next_vis, next_line
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical pixel counters and raw
// (pre-register) sync, visible and strobe decode.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP      = vga_timing_pkg::V_FP,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP
) (
  input logic          PCLK,
  input logic          RST,
  vga_scanout_if.master tm
);
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  hcnt_t hcount_q, hcount_d;
  vcnt_t vcount_q, vcount_d;
  vcnt_t next_line;

  // Next counter values: h wraps each line, v wraps each frame.
  always_comb begin
    hcount_d = hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (hcount_q == hcnt_t'(H_TOTAL - 1)) begin
      hcount_d = '0;
      if (vcount_q == vcnt_t'(V_TOTAL - 1))
        vcount_d = '0;
      else
        vcount_d = vcount_q + 1'b1;
    end
  end

  // Counter state.
  always_ff @(posedge PCLK) begin
    if (RST) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign next_line = (vcount_q == vcnt_t'(V_TOTAL - 1))
                   ? '0 : vcount_q + 1'b1;

  assign tm.hsync_n = !((hcount_q >= hcnt_t'(HS_START)) &&
                        (hcount_q <= hcnt_t'(HS_END)));
  assign tm.vsync_n = !((vcount_q >= vcnt_t'(VS_START)) &&
                        (vcount_q <= vcnt_t'(VS_END)));
  assign tm.visible = (hcount_q < hcnt_t'(H_VISIBLE)) &&
                      (vcount_q < vcnt_t'(V_VISIBLE));
  assign tm.vblank      = vcount_q >= vcnt_t'(V_VISIBLE);
  assign tm.frame_start = (hcount_q == '0) && (vcount_q == '0);
  assign tm.fetch       = hcount_q == hcnt_t'(H_VISIBLE);
  assign tm.line_end    = hcount_q == hcnt_t'(H_TOTAL - 1);
  assign tm.next_line   = next_line;
  assign tm.next_vis    = next_line < vcnt_t'(V_VISIBLE);
endmodule

// File: rtl/vga_scanout.sv
// VRAM line fetch, 1bpp pixel serialiser and registered VGA outputs.
// Every output lags the counter state that produced it by one PCLK.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP      = vga_timing_pkg::V_FP,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP
) (
  input  logic                 PCLK,
  input  logic                 RST,
  output logic [8:0]           agp_addr,
  input  logic [H_VISIBLE-1:0] agp_data,
  output logic                 hsync,
  output logic                 vsync,
  output logic [4:0]           rgb,
  output logic                 vblank,
  output logic                 frame_start
);
  vga_scanout_if tm ();

  vga_timing_gen #(
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_timing (
    .PCLK (PCLK),
    .RST  (RST),
    .tm   (tm)
  );

  logic [H_VISIBLE-1:0] shift_q, shift_d;
  logic [8:0]           addr_q, addr_d;
  logic [4:0]           rgb_q, rgb_d;
  logic                 hsync_q, vsync_q, vblank_q, fs_q;

  // Fetch address and line shifter: load at line end, shift while visible.
  always_comb begin
    addr_d  = addr_q;
    shift_d = shift_q;
    if (tm.fetch)
      addr_d = 9'(tm.next_line);
    if (tm.line_end)
      shift_d = tm.next_vis ? agp_data : '0;
    else if (tm.visible)
      shift_d = {1'b0, shift_q[H_VISIBLE-1:1]};
    rgb_d = (tm.visible && shift_q[0]) ? FG_COLOR : BG_COLOR;
  end

  // Datapath and output registers.
  always_ff @(posedge PCLK) begin
    if (RST) begin
      shift_q  <= '0;
      addr_q   <= '0;
      rgb_q    <= BG_COLOR;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      vblank_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      rgb_q    <= rgb_d;
      hsync_q  <= tm.hsync_n;
      vsync_q  <= tm.vsync_n;
      vblank_q <= tm.vblank;
      fs_q     <= tm.frame_start;
    end
  end

  assign agp_addr    = addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;
  assign vblank      = vblank_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Scanout bench: short vertical geometry, random VRAM with a 4-cycle
// read pipe, per-cycle compare against a position-based frame model.
module tb_vga_scanout;
  localparam int VV  = 16;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VB  = 2;
  localparam int VT  = VV + VFP + VS + VB;
  localparam int HV  = 640;
  localparam int HT  = 800;
  localparam int FT  = HT * VT;
  localparam int LAT = 4;
  localparam logic [4:0] FG = 5'b11111;
  localparam logic [4:0] BG = 5'b00000;

  logic         PCLK = 1'b0;
  logic         RST  = 1'b1;
  logic [8:0]   agp_addr;
  logic [639:0] agp_data;
  logic         hsync, vsync, vblank, frame_start;
  logic [4:0]   rgb;

  logic [639:0] vram  [VV];
  logic [639:0] shown [VV];
  logic [639:0] pipe  [LAT];

  int checks = 0;
  int failures = 0;
  int p = 0;
  int fidx = 0;

  int hs_first = -1, hs_len = 0, vs_len = 0;
  int l5_cnt = 0, l10_cnt = 0, l10_pos = -1, fs_cnt = 0;

  always #5 PCLK = ~PCLK;

  vga_scanout #(
    .V_VISIBLE (VV),
    .V_FP      (VFP),
    .V_SYNC    (VS),
    .V_BP      (VB)
  ) dut (
    .PCLK        (PCLK),
    .RST         (RST),
    .agp_addr    (agp_addr),
    .agp_data    (agp_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  always @(posedge PCLK) begin
    pipe[0] <= (agp_addr < 9'(VV)) ? vram[agp_addr[3:0]] : '0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign agp_data = pipe[LAT-1];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s p=%0d f=%0d got=%h want=%h",
               tag, p, fidx, obs, exp);
    end
  endtask

  function automatic int nl(input int v);
    return (v == VT - 1) ? 0 : v + 1;
  endfunction

  function automatic logic [639:0] rnd_line();
    logic [639:0] l;
    for (int k = 0; k < 20; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // One PCLK: drive reset, predict the outputs, compare at negedge.
  task automatic step(input bit r);
    int h, v, f;
    logic [17:0] e;
    logic [639:0] ln;
    logic px;
    logic [8:0] ea;
    h = p % HT;
    v = p / HT;
    f = fidx;
    RST = r;
    @(posedge PCLK);
    if (r) begin
      e = {1'b1, 1'b1, BG, 1'b0, 1'b0, 9'd0};
      p = 0;
      fidx = 0;
    end else begin
      if (h == HT - 1 && nl(v) < VV)
        shown[nl(v)] = vram[nl(v)];
      px = 1'b0;
      if (h < HV && v < VV) begin
        ln = (f == 0 && v == 0) ? '0 : shown[v];
        px = ln[h];
      end
      ea = (h >= HV) ? 9'(nl(v)) : 9'(v);
      e = {!(h >= 656 && h <= 751),
           !(v >= VV + VFP && v <= VV + VFP + VS - 1),
           px ? FG : BG, v >= VV, p == 0, ea};
      p++;
      if (p == FT) begin
        p = 0;
        fidx++;
      end
    end
    @(negedge PCLK);
    chk("outs", 32'({hsync, vsync, rgb, vblank, frame_start, agp_addr}),
        32'(e));
    if (frame_start) fs_cnt++;
    if (!r && f == 1) begin
      if (v == 3 && !hsync) begin
        if (hs_first < 0) hs_first = h + 1;
        hs_len++;
      end
      if (!vsync) vs_len++;
      if (v == 5 && rgb == FG) l5_cnt++;
      if (v == 10 && rgb == FG) begin
        l10_cnt++;
        if (l10_pos < 0) l10_pos = h + 1;
      end
    end
    if (p % HT == HT - 1 && nl(p / HT) < VV)
      chk("addr_ld", 32'(agp_addr < 9'(VV)), 32'd1);
    if (fidx == 1 && p == 12 * HT + 100)
      vram[12] = ~vram[12];
  endtask

  initial begin
    for (int i = 0; i < VV; i++) begin
      vram[i]  = rnd_line();
      shown[i] = '0;
    end
    vram[5]  = '1;
    vram[10] = 640'h1;

    repeat (3) step(1);
    chk("rst_hs", 32'(hsync), 32'd1);
    chk("rst_vs", 32'(vsync), 32'd1);
    chk("rst_rgb", 32'(rgb), 32'(BG));
    chk("rst_vb", 32'(vblank), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_addr", 32'(agp_addr), 32'd0);

    for (int n = 0; n < 3 * FT; n++) begin
      if (fidx == 2 && p == 15 * HT + 700) break;
      step(0);
    end
    chk("mid_pos", 32'(p), 32'(15 * HT + 700));

    step(1);
    chk("mrst_hs", 32'(hsync), 32'd1);
    chk("mrst_vs", 32'(vsync), 32'd1);
    chk("mrst_rgb", 32'(rgb), 32'(BG));
    step(0);
    chk("mrst_fs", 32'(frame_start), 32'd1);
    repeat (FT + 100) step(0);

    chk("hs_start", 32'(hs_first), 32'd657);
    chk("hs_len", 32'(hs_len), 32'd96);
    chk("vs_len", 32'(vs_len), 32'(VS * HT));
    chk("l5_cnt", 32'(l5_cnt), 32'd640);
    chk("l10_cnt", 32'(l10_cnt), 32'd1);
    chk("l10_pos", 32'(l10_pos), 32'd1);
    chk("fs_cnt", 32'(fs_cnt), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
